// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing defaults, derived totals, sync window bounds and sync polarity.
package vga_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
  localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

  localparam int   CNT_W       = 10;
  localparam logic SYNC_ACTIVE = 1'b0;

  function automatic logic sync_level(input logic [CNT_W-1:0] cnt,
                                      input logic [CNT_W-1:0] first,
                                      input logic [CNT_W-1:0] last);
    return (cnt >= first && cnt <= last) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick.sv
// Clock divider producing a one-clk pixel-advance strobe every CLK_DIV system clocks.
module vga_pixel_tick
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic p_tick_o
);

  localparam int            W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_pixel_tick: CLK_DIV must be in 1..16");
  end

  logic [W-1:0] div_q, div_d;

  // With CLK_DIV=1 the counter sits at 0 == LAST, so the strobe is permanently high.
  assign p_tick_o = (div_q == LAST);

  always_comb begin
    div_d = div_q + W'(1);
    if (p_tick_o) div_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) div_q <= '0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters, sync decode, blanking and colour path.
// Define VGA_SYNC_RGB_REG_EN to register rgb and add a matching sync stage at the pins.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] rgb_in_i,
  output logic       p_tick_o,
  output logic [9:0] pix_x_o,
  output logic [9:0] pix_y_o,
  output logic       video_on_o,
  output logic       frame_tick_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [2:0] rgb_o
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DISP   = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_DISP   = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic             p_tick;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             hs_q, hs_d, vs_q, vs_d;
  logic             frame_q, frame_d;
  logic             video_on;
  logic [2:0]       rgb_blank;

  vga_pixel_tick #(.CLK_DIV(CLK_DIV)) u_pixel_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .p_tick_o (p_tick)
  );

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    frame_d = 1'b0;
    if (p_tick) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        if (v_q == V_MAX) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + CNT_W'(1);
        end
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
    // Decoding the next counts lets the sync flops switch on the same edge as the counters.
    hs_d = sync_level(h_d, HS_FIRST, HS_LAST);
    vs_d = sync_level(v_d, VS_FIRST, VS_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= ~SYNC_ACTIVE;
      vs_q    <= ~SYNC_ACTIVE;
      frame_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      frame_q <= frame_d;
    end
  end

  assign video_on  = (h_q < H_DISP) && (v_q < V_DISP);
  assign rgb_blank = video_on ? rgb_in_i : 3'b000;

  assign p_tick_o     = p_tick;
  assign pix_x_o      = h_q;
  assign pix_y_o      = v_q;
  assign video_on_o   = video_on;
  assign frame_tick_o = frame_q;

`ifdef VGA_SYNC_RGB_REG_EN
  logic [2:0] rgb_q;
  logic       hs_pin_q, vs_pin_q;

  // Colour for the pixel just left is captured on the tick; syncs get the same one-tick delay.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rgb_q    <= 3'b000;
      hs_pin_q <= ~SYNC_ACTIVE;
      vs_pin_q <= ~SYNC_ACTIVE;
    end else if (p_tick) begin
      rgb_q    <= rgb_blank;
      hs_pin_q <= hs_q;
      vs_pin_q <= vs_q;
    end
  end

  assign rgb_o   = rgb_q;
  assign hsync_o = hs_pin_q;
  assign vsync_o = vs_pin_q;
`else
  assign rgb_o   = rgb_blank;
  assign hsync_o = hs_q;
  assign vsync_o = vs_q;
`endif

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA 640x480 raster timing generator that drives the pixel-coordinate interface consumed by the graphics generators (pong graph/animate): `pix_x`, `pix_y`, `video_on`, plus `hsync`/`vsync` to the connector. It divides the system clock down to a pixel tick, runs horizontal and vertical counters, and decodes sync and blanking. It also returns the 3-bit graphics colour to the DAC pins, forcing black outside the active area.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; 1 means a tick every clock. Legal range 1..16.
- `H_DISPLAY`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing in pixels.
- `V_DISPLAY`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing in lines.
- `clk` in 1: single system clock.
- `rst` in 1: asynchronous, active-high reset.
- `rgb_in` in 3: colour from the graphics generator for the current `pix_x`/`pix_y`.
- `p_tick` out 1: one-`clk` pixel-advance strobe.
- `pix_x` out 10: horizontal count, 0..799.
- `pix_y` out 10: vertical count, 0..524.
- `video_on` out 1: high when `pix_x < H_DISPLAY` and `pix_y < V_DISPLAY`.
- `frame_tick` out 1: one-`clk` pulse on the wrap (799,524)→(0,0).
- `hsync`, `vsync` out 1 each: sync outputs, active-low.
- `rgb` out 3: colour to the DAC.

## Operation
- **Divider.**
  - `div_cnt` counts 0..CLK_DIV-1.
  - `p_tick` = (`div_cnt` == CLK_DIV-1), combinational from the register.
  - With CLK_DIV=1, `p_tick` is constantly 1 once out of reset.
- **Counters.** `h_cnt` and `v_cnt` change only on a `clk` edge where `p_tick`=1.
  - `h_cnt` wraps at H_TOTAL-1 (799) → 0.
  - `v_cnt` increments only when `h_cnt` wraps, and wraps at V_TOTAL-1 (524) → 0.
  - `pix_x` = `h_cnt`, `pix_y` = `v_cnt`, driven directly from the registers.
- **Sync.** Registered, computed from the next counter values so they change on the same edge as the counters.
  - `hsync`=0 for `h_cnt` in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] = [656, 751].
  - `vsync`=0 for `v_cnt` in [490, 491].
- **`video_on`.** Combinational decode of the counters.
- **`frame_tick`.** Registered; high for exactly one `clk` on the edge where both counters wrap to 0.
- **Colour.** `rgb` = `video_on` ? `rgb_in` : 3'b000 (timing depends on configuration).
- **Reset** (asynchronous; also applies when asserted mid-frame):
  - `div_cnt`, `h_cnt`, `v_cnt` = 0.
  - `hsync`, `vsync` = 1.
  - `frame_tick` = 0; `p_tick` = 0 for CLK_DIV>1 and 1 for CLK_DIV=1.
  - `video_on` = 1 (counters at 0,0).
  - `rgb` = 0 with the macro; without it, `rgb` = `rgb_in`.
  - Release restarts the frame at (0,0) with no partial pulses.
- **Widths.** Counters are 10-bit unsigned. H_TOTAL and V_TOTAL must be ≤1024; elaboration errors otherwise.

## Timing
- Line = 800 pixel ticks; frame = 525 lines = 420000 ticks = 840000 `clk` at CLK_DIV=2.
- `hsync` low for 96 ticks per line; `vsync` low for 2 full lines per frame.
- Consumer's refresh condition (`pix_y`==481 && `pix_x`==0) is true for exactly one pixel period per frame (CLK_DIV `clk` cycles).
- `frame_tick` follows the wrap edge with latency 0: it is high during the first `clk` at (0,0).
- Counter-to-`rgb` latency: 0 without the macro, 1 pixel tick with it.

## Configuration
- **`VGA_SYNC_RGB_REG_EN` defined:**
  - `rgb` is a register loaded on `p_tick` with the blanked `rgb_in`.
  - `hsync`/`vsync` pass through one extra `p_tick`-enabled stage (reset value 1), so sync and colour stay aligned at the pins.
  - `video_on`, `pix_x`, `pix_y` are not delayed.
- **Not defined:** `rgb` is combinational and the syncs have no extra stage.

## Structure
- Shared package `vga_pkg` holds:
  - the default timing localparams;
  - derived H_TOTAL/V_TOTAL;
  - sync start/end constants;
  - the `SYNC_ACTIVE` = 1'b0 polarity constant.
- One natural sub-module, `vga_pixel_tick`: the CLK_DIV divider producing `p_tick`.
- Counters, sync decode and the colour path stay in `vga_sync_gen`.

## Test plan
- **Reset then release, CLK_DIV=2:**
  - `p_tick` high on every 2nd `clk`.
  - `pix_x` increments 0,1,2…; `hsync`=`vsync`=1.
  - `video_on`=1.
- **Run one line:**
  - `hsync` falls when `pix_x`=656 and rises when `pix_x`=752 (96 ticks low).
  - `video_on` falls at `pix_x`=640.
  - `pix_x` wraps 799→0 and `pix_y` goes 0→1 on the same edge.
- **Run a full frame:**
  - `vsync` low exactly while `pix_y`∈{490,491}.
  - `frame_tick` pulses once per 840000 `clk`.
  - (`pix_y`==481 && `pix_x`==0) is true for 2 `clk` per frame.
- **`rgb_in`=3'b110 constant:**
  - `rgb`=3'b110 only for `pix_x`<640 and `pix_y`<480, else 0.
  - With the macro, `rgb` lags the window by 1 tick and syncs lag by 1 tick.
- **Assert `rst` at `pix_x`=700, `pix_y`=300 mid-`hsync`:**
  - outputs return to reset values immediately, without waiting for a clock edge;
  - after release, a clean line restarts at (0,0).
- **CLK_DIV=1:** `p_tick` continuously high; one line = 800 `clk`.
